// File: rtl/ram_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : ram_alu_seq
// Purpose  : Register-mapped sequential ALU. The host writes operands X and Y,
//            then issues START. op0 computes X*X - Y*Y (mod 2^(2W)) in one
//            cycle. ops 1-3 run a W-cycle restoring divider:
//              op1 = X mod Y, op2 = X / Y, op3 = X mod (X-Y).
//            Result and status are read back through the same address port.
// Ports    : clk   - clock, rising edge
//            rst   - asynchronous active-high reset
//            e     - block enable (gates w and r)
//            op    - operation select, sampled at START
//            DIn   - write data (W bits)
//            addr  - register address: 0=X, 1=Y, 2=START/result, 3=status
//            w, r  - write / read strobes
//            DOut  - registered read data (2W bits)
//            busy  - operation in progress
//            done  - one-cycle completion pulse
// Options  : ALU_AUTOSTART_EN - when defined, an accepted write to Y while
//            idle also starts the operation with the newly written Y.
// Revision : 1.0 - initial release
// ============================================================================
module ram_alu_seq #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e,
    input  logic [1:0]       op,
    input  logic [W-1:0]     DIn,
    input  logic [1:0]       addr,
    input  logic             w,
    input  logic             r,
    output logic [2*W-1:0]   DOut,
    output logic             busy,
    output logic             done
);

    localparam int                 c_CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(W - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [W-1:0]         r_x;
    logic [W-1:0]         r_y;
    logic [W-1:0]         r_ax;       // operands latched at START
    logic [W-1:0]         r_ay;
    logic [1:0]           r_op;
    logic [2*W-1:0]       r_result;
    logic                 r_ovr;
    logic                 r_dz;
    logic [1:0]           r_lastop;
    logic [2*W-1:0]       r_dout;
    logic                 r_busy;
    logic                 r_done;

    logic [W-1:0]         r_rem;      // partial remainder
    logic [W-1:0]         r_quo;      // dividend shifts out, quotient shifts in
    logic [W-1:0]         r_div;      // divisor
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_wr;
    logic                 w_idle;
    logic                 w_start_a2;
    logic                 w_start_y;
    logic                 w_start;
    logic [W-1:0]         w_d;
    logic                 w_dz;
    logic [2*W-1:0]       w_xe;
    logic [2*W-1:0]       w_ye;
    logic [2*W-1:0]       w_sq;
    logic [W:0]           w_shift;
    logic [W:0]           w_trial;
    logic                 w_ge;
    logic [W-1:0]         w_rem_nxt;
    logic [W-1:0]         w_quo_nxt;
    logic [2*W-1:0]       w_status;

    // ------------------------------------------------------------------------
    // Host decode. DONE counts as idle so back-to-back STARTs are accepted.
    // ------------------------------------------------------------------------
    assign w_wr       = e & w;
    assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_start_a2 = w_wr && (addr == 2'd2) && w_idle;
`ifdef ALU_AUTOSTART_EN
    assign w_start_y  = w_wr && (addr == 2'd1) && w_idle;
`else
    assign w_start_y  = 1'b0;
`endif
    assign w_start    = w_start_a2 | w_start_y;

    // ------------------------------------------------------------------------
    // Datapath combinational logic
    // ------------------------------------------------------------------------
    assign w_d  = (r_op == 2'd3) ? (r_ax - r_ay) : r_ay;
    assign w_dz = (w_d == '0);

    // X*X - Y*Y == (X+Y)*(X-Y); evaluated at 2W bits so it wraps naturally.
    assign w_xe = {{W{1'b0}}, r_ax};
    assign w_ye = {{W{1'b0}}, r_ay};
    assign w_sq = (w_xe + w_ye) * (w_xe - w_ye);

    // One restoring step. Since rem < div, the trial difference fits in W
    // bits whenever it is non-negative; bit W is the borrow.
    assign w_shift   = {r_rem, r_quo[W-1]};
    assign w_trial   = w_shift - {1'b0, r_div};
    assign w_ge      = ~w_trial[W];
    assign w_rem_nxt = w_ge ? w_trial[W-1:0] : w_shift[W-1:0];
    assign w_quo_nxt = {r_quo[W-2:0], w_ge};

    assign w_status  = {{(2*W-5){1'b0}}, r_lastop, r_ovr, r_dz, r_busy};

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_CALC;
            end
            S_CALC: begin
                if (r_op == 2'd0 || w_dz) w_state_nxt = S_DONE;
                else                      w_state_nxt = S_DIV;
            end
            S_DIV: begin
                if (r_cnt == c_LAST) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = w_start ? S_CALC : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM state register; busy/done are registered from the next state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_CALC) || (w_state_nxt == S_DIV);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // ------------------------------------------------------------------------
    // Registers, datapath and read port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_ax     <= '0;
            r_ay     <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_ovr    <= 1'b0;
            r_dz     <= 1'b0;
            r_lastop <= '0;
            r_dout   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
        end else begin
            // Operand writes are dropped while an operation is running.
            if (w_wr && addr == 2'd0) begin
                if (r_busy) r_ovr <= 1'b1;
                else        r_x   <= DIn;
            end
            if (w_wr && addr == 2'd1) begin
                if (r_busy) r_ovr <= 1'b1;
                else        r_y   <= DIn;
            end

            if (w_start) begin
                r_ax  <= r_x;
                r_ay  <= w_start_y ? DIn : r_y;
                r_op  <= op;
                r_ovr <= 1'b0;
                r_dz  <= 1'b0;
            end

            case (r_state)
                S_CALC: begin
                    if (r_op == 2'd0) begin
                        r_result <= w_sq;
                    end else if (w_dz) begin
                        r_dz     <= 1'b1;
                        r_result <= (r_op == 2'd2) ? {{W{1'b0}}, {W{1'b1}}}
                                                   : {{W{1'b0}}, r_ax};
                    end else begin
                        r_rem <= '0;
                        r_quo <= r_ax;
                        r_div <= w_d;
                        r_cnt <= '0;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_result <= (r_op == 2'd2) ? {{W{1'b0}}, w_quo_nxt}
                                                   : {{W{1'b0}}, w_rem_nxt};
                    end
                end
                default: ;
            endcase

            if (r_busy && w_state_nxt == S_DONE) r_lastop <= r_op;

            // Reads see register values from before this edge's updates.
            if (e && r) begin
                case (addr)
                    2'd0:    r_dout <= {{W{1'b0}}, r_x};
                    2'd1:    r_dout <= {{W{1'b0}}, r_y};
                    2'd2:    r_dout <= r_result;
                    default: r_dout <= w_status;
                endcase
            end
        end
    end

    assign DOut = r_dout;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire
